// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle restoring divider (DIV/DIVU), one quotient bit per
//            cycle, result {hi = remainder, lo = quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int         CW   = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [WIDTH-1:0]   dvs_q,    dvs_d;
    logic               negq_q,   negq_d;
    logic               negr_q,   negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     trial;
    logic               no_borrow;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   fix_rem;
    logic [WIDTH-1:0]   fix_quo;

    // Magnitudes; the most negative value maps onto itself and is then
    // treated as an unsigned magnitude by the datapath.
    assign abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
    assign abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

    // One restoring step on the left-shifted {rem, quo} pair.
    assign trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign no_borrow = ~trial[WIDTH];
    assign step_rem  = no_borrow ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign step_quo  = {quo_q[WIDTH-2:0], no_borrow};
    assign fix_rem   = negr_q ? -step_rem : step_rem;
    assign fix_quo   = negq_q ? -step_quo : step_quo;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    busy    = 1'b1;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    count_d = '0;
                    negq_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d  = signed_div & a[WIDTH-1];
                    if (b == '0) begin
                        state_d  = DONE;
                        result_d = {a, {WIDTH{1'b1}}};
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d  = DONE;
                        result_d = {fix_rem, fix_quo};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    // A cancel arriving in the completion cycle suppresses the pulse.
    assign ready  = (state_q == DONE) && !annul;
    assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Self-checking bench for div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        start      = 1'b0;
    logic        signed_div = 1'b0;
    logic        annul      = 1'b0;
    logic [31:0] a          = '0;
    logic [31:0] b          = '0;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: cycles of work left, completion flag, visible result.
    int          m_wait = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = {32'd0, x};
            sy = {32'd0, y};
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_wait = 0;
                m_done = 1'b0;
                m_res  = '0;
            end else if (annul) begin
                m_wait = 0;
                m_done = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (start) begin
                if (b == 32'd0) begin
                    m_done = 1'b1;
                    m_res  = ref_div(a, b, signed_div);
                end else begin
                    m_wait = 32;
                    m_pend = ref_div(a, b, signed_div);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("busy", busy, ((m_wait > 0) || (!m_done && start && !annul)) ? 64'd1 : 64'd0);
                chk("ready", ready, (m_done && !annul) ? 64'd1 : 64'd0);
                chk("result", result, m_res);
            end
        end
    end

    // Called positioned just after a rising edge; returns likewise.
    task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [63:0] exp, input int lat);
        int cyc   = 0;
        int nbusy = 0;
        bit got   = 1'b0;
        start = 1'b1; a = x; b = y; signed_div = s;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (ready) begin
                got = 1'b1;
                chk({nm, " result"},  result, exp);
                chk({nm, " latency"}, 64'(cyc), 64'(lat));
                chk({nm, " busy cycles"}, 64'(nbusy), 64'(lat));
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (!got) chk({nm, " timeout"}, 64'd0, 64'd1);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] prev;
        logic [31:0] x, y;
        logic        s;
        int          sel;

        chk("model -7/2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model ovf",  ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'h0, 32'h8000_0000});

        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset ready",  ready,  64'd0);
        chk("reset busy",   busy,   64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("divu 7/2",  32'd7,          32'd2,          1'b0, {32'h1, 32'h3}, 33);
        @(posedge clk); #1;
        run_op("div -7/2",  32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("div 7/-2",  32'd7,          32'hFFFF_FFFE,  1'b1, {32'h1, 32'hFFFF_FFFD}, 33);
        run_op("div ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0, 32'h8000_0000}, 33);
        run_op("divu max/1",32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0, 32'hFFFF_FFFF}, 33);
        run_op("div by 0",  32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 1);

        // Cancel partway through a run.
        prev  = {32'h1234_5678, 32'hFFFF_FFFF};
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("annul ready",  ready,  64'd0);
        chk("annul busy",   busy,   64'd0);
        chk("annul result", result, prev);
        @(posedge clk); #1;
        run_op("after annul 100/7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

        // Asynchronous reset in the middle of a run, start kept high.
        start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst ready",  ready,  64'd0);
        chk("async rst result", result, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_op("restart 1000/3", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 33);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            x   = $urandom;
            s   = 1'($urandom_range(0, 1));
            case (sel)
                0:       y = 32'd0;
                1, 2:    y = 32'($urandom_range(1, 15));
                3:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_op("random", x, y, s, ref_div(x, y, s), (y == 32'd0) ? 1 : 33);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
